baud_rate_gen: RTL and testbench

Runtime-programmable fractional baud tick generator for the UART core. It produces an oversample tick, a mid-bit sample tick and a bit-boundary tick from a divisor with integer and fractional parts. Divisor updates are glitch-free: they are shadowed and applied only at bit boundaries or while idle. It sits between the system clock and the UART TX/RX engines; RX uses `resync` to phase-align to the start bit.

---
 rtl/baud_pkg.sv | 19 +
 rtl/baud_frac_accum.sv | 35 +++
 rtl/baud_rate_gen.sv | 152 +++++++++++++++
 tb/tb_baud_rate_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared constants for the fractional baud tick generator.
package baud_pkg;

  localparam int DEFAULT_DIV_W      = 16;
  localparam int DEFAULT_FRAC_W     = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DIV_INT    = 325;
  localparam int DEFAULT_DIV_FRAC   = 133;
  localparam int PHASE_W            = $clog2(DEFAULT_OVERSAMPLE);
  localparam int MIN_DIV            = 2;

  // Where the next active divisor comes from when an apply point is reached.
  typedef enum logic [1:0] {
    APPLY_NONE   = 2'd0,
    APPLY_SHADOW = 2'd1,
    APPLY_DIRECT = 2'd2
  } apply_src_e;

endpackage

// File: rtl/baud_frac_accum.sv
// Fractional phase accumulator: adds frac on every step and exposes the carry
// as a one-cycle period extension for the following oversample period.
module baud_frac_accum
  import baud_pkg::*;
#(
  parameter int FRAC_W = DEFAULT_FRAC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              extra
);

  logic [FRAC_W-1:0] r_acc;
  logic              r_extra;
  logic [FRAC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, frac};

  // clear outranks step so a divisor change starts from zero phase error
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_acc   <= '0;
      r_extra <= 1'b0;
    end else if (step) begin
      r_acc   <= w_sum[FRAC_W-1:0];
      r_extra <= w_sum[FRAC_W];
    end
  end

  assign extra = r_extra;

endmodule

// File: rtl/baud_rate_gen.sv
// Fractional baud tick generator: oversample, mid-bit and bit-boundary ticks,
// with shadowed divisor updates applied only at bit boundaries, idle or resync.
module baud_rate_gen
  import baud_pkg::*;
#(
  parameter int DIV_W            = DEFAULT_DIV_W,
  parameter int FRAC_W           = DEFAULT_FRAC_W,
  parameter int OVERSAMPLE       = DEFAULT_OVERSAMPLE,
  parameter int DEFAULT_DIV_INT  = baud_pkg::DEFAULT_DIV_INT,
  parameter int DEFAULT_DIV_FRAC = baud_pkg::DEFAULT_DIV_FRAC
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          resync,
  input  logic                          div_load,
  input  logic [DIV_W-1:0]              div_int_in,
  input  logic [FRAC_W-1:0]             div_frac_in,
  output logic                          os_tick,
  output logic                          mid_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
  output logic                          load_pending
);

  localparam int LP_PHASE_W = (OVERSAMPLE == DEFAULT_OVERSAMPLE) ? PHASE_W
                                                                 : $clog2(OVERSAMPLE);
  localparam logic [LP_PHASE_W-1:0] LP_MID_PHASE  = LP_PHASE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [LP_PHASE_W-1:0] LP_LAST_PHASE = LP_PHASE_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0]      LP_MIN_DIV    = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0]      LP_RST_INT    = DIV_W'(DEFAULT_DIV_INT);
  localparam logic [FRAC_W-1:0]     LP_RST_FRAC   = FRAC_W'(DEFAULT_DIV_FRAC);

  logic [DIV_W:0]          r_cnt;
  logic [LP_PHASE_W-1:0]   r_phase;
  logic                    r_os_tick;
  logic                    r_mid_tick;
  logic                    r_bit_tick;
  logic [DIV_W-1:0]        r_div_int;
  logic [FRAC_W-1:0]       r_div_frac;
  logic [DIV_W-1:0]        r_shd_int;
  logic [FRAC_W-1:0]       r_shd_frac;
  logic                    r_pending;

  logic [DIV_W-1:0]        w_div_in_clamped;
  logic                    w_extra;
  logic [DIV_W:0]          w_term;
  logic                    w_wrap;
  logic                    w_bit_point;
  logic                    w_apply_point;
  apply_src_e              w_apply_src;
  logic                    w_apply;
  logic [DIV_W-1:0]        w_new_int;
  logic [FRAC_W-1:0]       w_new_frac;
  logic                    w_acc_clear;
  logic                    w_acc_step;

  assign w_div_in_clamped = (div_int_in < LP_MIN_DIV) ? LP_MIN_DIV : div_int_in;

  // One extra bit keeps div_int - 1 + extra from wrapping.
  assign w_term = {1'b0, r_div_int} - (DIV_W + 1)'(1) + {{DIV_W{1'b0}}, w_extra};

  assign w_wrap        = enable && (r_cnt == w_term);
  assign w_bit_point   = w_wrap && (r_phase == LP_LAST_PHASE);
  assign w_apply_point = resync || !enable || w_bit_point;

  // A load landing on an apply point bypasses the shadow entirely.
  always_comb begin
    w_apply_src = APPLY_NONE;
    w_new_int   = r_shd_int;
    w_new_frac  = r_shd_frac;
    if (w_apply_point) begin
      if (div_load) begin
        w_apply_src = APPLY_DIRECT;
        w_new_int   = w_div_in_clamped;
        w_new_frac  = div_frac_in;
      end else if (r_pending) begin
        w_apply_src = APPLY_SHADOW;
      end
    end
  end

  assign w_apply     = (w_apply_src != APPLY_NONE);
  assign w_acc_clear = resync || w_apply;
  assign w_acc_step  = w_wrap && !resync;

  baud_frac_accum #(
    .FRAC_W (FRAC_W)
  ) u_frac_accum (
    .clock (clock),
    .reset (reset),
    .clear (w_acc_clear),
    .step  (w_acc_step),
    .frac  (r_div_frac),
    .extra (w_extra)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div_int  <= LP_RST_INT;
      r_div_frac <= LP_RST_FRAC;
      r_shd_int  <= LP_RST_INT;
      r_shd_frac <= LP_RST_FRAC;
      r_pending  <= 1'b0;
    end else begin
      if (div_load) begin
        r_shd_int  <= w_div_in_clamped;
        r_shd_frac <= div_frac_in;
      end
      if (w_apply) begin
        r_div_int  <= w_new_int;
        r_div_frac <= w_new_frac;
        r_pending  <= 1'b0;
      end else if (div_load) begin
        r_pending  <= 1'b1;
      end
    end
  end

  // Ticks are decoded from the phase before it advances.
  always_ff @(posedge clock) begin
    if (reset || resync) begin
      r_cnt      <= '0;
      r_phase    <= '0;
      r_os_tick  <= 1'b0;
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (!enable) begin
      r_os_tick  <= 1'b0;
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (w_wrap) begin
      r_cnt      <= '0;
      r_phase    <= r_phase + LP_PHASE_W'(1);
      r_os_tick  <= 1'b1;
      r_mid_tick <= (r_phase == LP_MID_PHASE);
      r_bit_tick <= (r_phase == LP_LAST_PHASE);
    end else begin
      r_cnt      <= r_cnt + (DIV_W + 1)'(1);
      r_os_tick  <= 1'b0;
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
    end
  end

  assign os_tick      = r_os_tick;
  assign mid_tick     = r_mid_tick;
  assign bit_tick     = r_bit_tick;
  assign os_phase     = r_phase;
  assign load_pending = r_pending;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen: periods, fractional spacing, shadow loads,
// resync and enable pause, all against hand-computed cycle counts.
module tb_baud_rate_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        resync;
  logic        div_load;
  logic [15:0] div_int_in;
  logic [7:0]  div_frac_in;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;
  logic [3:0]  os_phase;
  logic        load_pending;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_os = 0;
  int g, bad, n_mid, n_bit, mid_cyc, bit_cyc, sum, seen;
  int exp_frac [10] = '{4, 4, 5, 4, 5, 4, 5, 4, 5, 4};

  always #5 clock = ~clock;

  baud_rate_gen dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .resync       (resync),
    .div_load     (div_load),
    .div_int_in   (div_int_in),
    .div_frac_in  (div_frac_in),
    .os_tick      (os_tick),
    .mid_tick     (mid_tick),
    .bit_tick     (bit_tick),
    .os_phase     (os_phase),
    .load_pending (load_pending)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Advance to the next os_tick; gap is measured from the previous tick.
  task automatic wait_os(output int gap);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (os_tick !== 1'b1 && n < 1000);
    if (os_tick !== 1'b1) check("os_tick timeout", 0, 1);
    gap     = cyc - last_os;
    last_os = cyc;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    resync      = 1'b0;
    div_load    = 1'b0;
    div_int_in  = '0;
    div_frac_in = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_idle(input int i, input int f);
    enable      = 1'b0;
    div_load    = 1'b1;
    div_int_in  = 16'(i);
    div_frac_in = 8'(f);
    tick();
    div_load    = 1'b0;
  endtask

  task automatic start();
    enable  = 1'b1;
    last_os = cyc;
  endtask

  initial begin
    // reset state and default divisor
    do_reset();
    check("rst os_tick", int'(os_tick), 0);
    check("rst mid_tick", int'(mid_tick), 0);
    check("rst bit_tick", int'(bit_tick), 0);
    check("rst os_phase", int'(os_phase), 0);
    check("rst load_pending", int'(load_pending), 0);
    start();
    wait_os(g);
    check("default period", g, 325);

    // int=4 frac=0: steady 4-cycle ticks, bit every 64, mid 32 before bit
    do_reset();
    load_idle(4, 0);
    check("t1 idle load pending", int'(load_pending), 0);
    start();
    bad = 0; n_mid = 0; n_bit = 0; mid_cyc = 0; bit_cyc = 0;
    for (int k = 1; k <= 32; k++) begin
      wait_os(g);
      if (g != 4) bad++;
      if (mid_tick) begin
        n_mid++;
        mid_cyc = cyc;
      end
      if (bit_tick) begin
        n_bit++;
        if (bit_cyc == 0) begin
          check("t1 first bit index", k, 16);
          check("t1 mid to bit", cyc - mid_cyc, 32);
        end else begin
          check("t1 bit spacing", cyc - bit_cyc, 64);
        end
        bit_cyc = cyc;
      end
    end
    check("t1 bad gaps", bad, 0);
    check("t1 mid count", n_mid, 2);
    check("t1 bit count", n_bit, 2);
    check("t1 phase wrap", int'(os_phase), 0);

    // int=4 frac=128: alternating 4/5 spacing
    do_reset();
    load_idle(4, 128);
    start();
    sum = 0;
    for (int k = 0; k < 10; k++) begin
      wait_os(g);
      check($sformatf("t2 gap %0d", k + 1), g, exp_frac[k]);
      if (k >= 1 && k <= 8) sum += g;
    end
    check("t2 gaps 2..9 sum", sum, 36);

    // shadowed load applied at bit boundary
    do_reset();
    load_idle(4, 0);
    start();
    repeat (3) wait_os(g);
    check("t3 phase at load", int'(os_phase), 3);
    div_load = 1'b1; div_int_in = 16'd8; div_frac_in = 8'd0;
    tick();
    div_load = 1'b0;
    check("t3 pending set", int'(load_pending), 1);
    bad = 0;
    for (int k = 4; k <= 16; k++) begin
      wait_os(g);
      if (g != 4) bad++;
      if (k == 15) check("t3 pending held", int'(load_pending), 1);
    end
    check("t3 bad gaps before boundary", bad, 0);
    check("t3 boundary bit_tick", int'(bit_tick), 1);
    check("t3 pending cleared", int'(load_pending), 0);
    wait_os(g);
    check("t3 new gap a", g, 8);
    wait_os(g);
    check("t3 new gap b", g, 8);

    // second load overwrites the pending one
    do_reset();
    load_idle(4, 0);
    start();
    repeat (2) wait_os(g);
    div_load = 1'b1; div_int_in = 16'd8;
    tick();
    div_load = 1'b0;
    wait_os(g);
    div_load = 1'b1; div_int_in = 16'd6;
    tick();
    div_load = 1'b0;
    check("t4 pending", int'(load_pending), 1);
    bad = 0;
    for (int k = 4; k <= 16; k++) begin
      wait_os(g);
      if (g != 4) bad++;
    end
    check("t4 bad gaps before boundary", bad, 0);
    wait_os(g);
    check("t4 new gap a", g, 6);
    wait_os(g);
    check("t4 new gap b", g, 6);

    // resync at cnt=2, phase=9; then resync applying a pending load
    do_reset();
    load_idle(4, 0);
    start();
    repeat (9) wait_os(g);
    check("t5 phase before resync", int'(os_phase), 9);
    tick();
    tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    check("t5 no tick on resync", int'(os_tick), 0);
    check("t5 phase cleared", int'(os_phase), 0);
    last_os = cyc;
    wait_os(g);
    check("t5 gap after resync", g, 4);
    check("t5 phase after tick", int'(os_phase), 1);
    div_load = 1'b1; div_int_in = 16'd6;
    tick();
    div_load = 1'b0;
    check("t5 pending before resync", int'(load_pending), 1);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    check("t5 pending applied by resync", int'(load_pending), 0);
    last_os = cyc;
    wait_os(g);
    check("t5 gap with resync-applied div", g, 6);

    // clamp to 2 and enable pause mid-period
    do_reset();
    load_idle(0, 0);
    start();
    wait_os(g);
    check("t6 clamped gap a", g, 2);
    wait_os(g);
    check("t6 clamped gap b", g, 2);
    tick();
    enable = 1'b0;
    seen = 0;
    repeat (10) begin
      tick();
      if (os_tick || mid_tick || bit_tick) seen++;
    end
    check("t6 ticks while disabled", seen, 0);
    check("t6 phase held", int'(os_phase), 2);
    enable = 1'b1;
    wait_os(g);
    check("t6 gap across pause", g, 12);
    wait_os(g);
    check("t6 gap after pause", g, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
